// File: rtl/mem_access_ctrl_if.sv
// CPU load/store port and data-RAM port of the memory access controller.
// slave: the controller's view. master: the CPU/RAM side that drives requests and read data.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_size;
  logic              cpu_sign;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;
  logic              cpu_busy;
  logic [ADDR_W-1:0] ram_addra;
  logic              ram_wea;
  logic [31:0]       ram_dina;
  logic [47:0]       ram_douta;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_sign, cpu_addr, cpu_wdata, ram_douta,
    output cpu_rdata, cpu_ready, cpu_err, cpu_busy, ram_addra, ram_wea, ram_dina
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_sign, cpu_addr, cpu_wdata, ram_douta,
    input  cpu_rdata, cpu_ready, cpu_err, cpu_busy, ram_addra, ram_wea, ram_dina
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store bridge between the CPU port and a 1-cycle-latency 32-bit data RAM.
// Checks alignment and range, performs read-modify-write for byte/half stores,
// and returns lane-extracted, sign/zero-extended load data. All outputs are registered.
module mem_access_ctrl #(
  parameter int ADDR_W = 20,
  parameter int WORDS  = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [29:0] WORDS_W = 30'(WORDS);

  state_t            state_r, state_s;
  logic              we_r, sign_r;
  logic [1:0]        size_r, lane_r;
  logic [31:0]       wdata_r;
  logic              req_err_s, size_err_s, range_err_s;

  logic [ADDR_W-1:0] ram_addra_r, ram_addra_s;
  logic              ram_wea_r, ram_wea_s;
  logic [31:0]       ram_dina_r, ram_dina_s;
  logic [31:0]       cpu_rdata_r, cpu_rdata_s;
  logic              cpu_ready_r, cpu_ready_s;
  logic              cpu_err_r, cpu_err_s;
  logic              cpu_busy_r, cpu_busy_s;

  // Upper read-data bits carry no information for this controller.
  logic              unused_douta_s;
  assign unused_douta_s = ^bus.ram_douta[47:32];

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sign);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{sign & b[7]}}, b};
      2'b01:   res = {{16{sign & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the right-justified store data onto the addressed lane of a word.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00: begin
        case (lane)
          2'b00:   res[7:0]   = wdata[7:0];
          2'b01:   res[15:8]  = wdata[7:0];
          2'b10:   res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) res[31:16] = wdata[15:0];
        else         res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Reject illegal size, misalignment, and word indices beyond the RAM depth.
  always_comb begin
    size_err_s  = 1'b0;
    range_err_s = (bus.cpu_addr[31:2] >= WORDS_W);
    case (bus.cpu_size)
      2'b00:   size_err_s = 1'b0;
      2'b01:   size_err_s = bus.cpu_addr[0];
      2'b10:   size_err_s = (bus.cpu_addr[1:0] != 2'b00);
      default: size_err_s = 1'b1;
    endcase
    req_err_s = size_err_s | range_err_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state: errors finish at once, word stores skip the read, everything else reads first.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!bus.cpu_req)                            state_s = IDLE;
        else if (req_err_s)                          state_s = DONE;
        else if (bus.cpu_we && bus.cpu_size == 2'b10) state_s = WR;
        else                                         state_s = RD1;
      end
      RD1:     state_s = RD2;
      RD2:     state_s = we_r ? WR : DONE;
      WR:      state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Capture the request attributes when a request is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      sign_r  <= 1'b0;
      size_r  <= 2'b00;
      lane_r  <= 2'b00;
      wdata_r <= 32'h0000_0000;
    end else if (state_r == IDLE && bus.cpu_req) begin
      we_r    <= bus.cpu_we;
      sign_r  <= bus.cpu_sign;
      size_r  <= bus.cpu_size;
      lane_r  <= bus.cpu_addr[1:0];
      wdata_r <= bus.cpu_wdata;
    end
  end

  // FSM outputs: next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    ram_addra_s = ram_addra_r;
    ram_dina_s  = ram_dina_r;
    cpu_rdata_s = cpu_rdata_r;
    ram_wea_s   = (state_s == WR);
    cpu_ready_s = (state_s == DONE);
    cpu_busy_s  = (state_s != IDLE);
    cpu_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cpu_req) begin
          ram_addra_s = bus.cpu_addr[ADDR_W+1:2];
          ram_dina_s  = bus.cpu_wdata;
          cpu_err_s   = req_err_s;
        end else begin
          cpu_err_s   = 1'b0;
        end
      end
      RD2: begin
        if (we_r) ram_dina_s  = lane_merge(bus.ram_douta[31:0], wdata_r, size_r, lane_r);
        else      cpu_rdata_s = lane_extract(bus.ram_douta[31:0], size_r, lane_r, sign_r);
      end
      default: cpu_err_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addra_r <= '0;
      ram_wea_r   <= 1'b0;
      ram_dina_r  <= 32'h0000_0000;
      cpu_rdata_r <= 32'h0000_0000;
      cpu_ready_r <= 1'b0;
      cpu_err_r   <= 1'b0;
      cpu_busy_r  <= 1'b0;
    end else begin
      ram_addra_r <= ram_addra_s;
      ram_wea_r   <= ram_wea_s;
      ram_dina_r  <= ram_dina_s;
      cpu_rdata_r <= cpu_rdata_s;
      cpu_ready_r <= cpu_ready_s;
      cpu_err_r   <= cpu_err_s;
      cpu_busy_r  <= cpu_busy_s;
    end
  end

  assign bus.ram_addra = ram_addra_r;
  assign bus.ram_wea   = ram_wea_r;
  assign bus.ram_dina  = ram_dina_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.cpu_ready = cpu_ready_r;
  assign bus.cpu_err   = cpu_err_r;
  assign bus.cpu_busy  = cpu_busy_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed requests push expected responses,
// a monitor pops and compares on every cpu_ready. Includes a 128x32 RAM model.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 20;
  localparam int WORDS  = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  // Cycle index of the current clock period.
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic [31:0] mem [0:WORDS-1];

  // RAM model: one-cycle read latency, garbage on the read port during writes.
  always @(posedge clk) begin
    if (bus.ram_wea) begin
      mem[bus.ram_addra[6:0]] <= bus.ram_dina;
      bus.ram_douta <= 48'h5A5A_0BAD_F00D;
    end else begin
      bus.ram_douta <= {16'hA5A5, mem[bus.ram_addra[6:0]]};
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wea;
    int          req_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   wea_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wea_cnt = 0;
      end else begin
        if (bus.ram_wea) wea_cnt++;
        if (bus.cpu_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("err", 32'(bus.cpu_err), 32'(e.err));
            chk("rdata", bus.cpu_rdata, e.rdata);
            chk("latency", 32'(cyc - e.req_cyc), 32'(e.lat));
            chk("wea_cycles", 32'(wea_cnt), 32'(e.wea));
          end
          wea_cnt = 0;
        end
      end
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat, input int wea);
    exp_t e;
    @(negedge clk);
    bus.cpu_we    = we;
    bus.cpu_size  = size;
    bus.cpu_sign  = sign;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_req   = 1'b1;
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.wea = wea; e.req_cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d responses outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ram_wea"},   32'(bus.ram_wea),   32'h0);
    chk({tag, "_ram_addra"}, 32'(bus.ram_addra), 32'h0);
    chk({tag, "_ram_dina"},  bus.ram_dina,       32'h0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata,      32'h0);
    chk({tag, "_cpu_ready"}, 32'(bus.cpu_ready), 32'h0);
    chk({tag, "_cpu_err"},   32'(bus.cpu_err),   32'h0);
    chk({tag, "_cpu_busy"},  32'(bus.cpu_busy),  32'h0);
  endtask

  initial begin
    exp_t e;
    int   rc;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'b00; bus.cpu_sign = 1'b0;
    bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    fork monitor(); join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk_outs_zero("reset");
    rst_n = 1'b1;

    // 1: word store then word load
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    chk("wr_busy", 32'(bus.cpu_busy), 32'h1);
    chk("wr_wea", 32'(bus.ram_wea), 32'h1);
    chk("wr_addra", 32'(bus.ram_addra), 32'h4);
    chk("wr_dina", bus.ram_dina, 32'hDEADBEEF);
    wait_done();
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
    wait_done();

    // 2: byte store with read-modify-write, then signed/unsigned byte loads
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 32'hDEADBEEF, 1'b0, 4, 1);
    wait_done();
    chk("mem4_after_byte", mem[4], 32'hDEADAAEF);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 0);
    wait_done();
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h000000AA, 1'b0, 3, 0);
    wait_done();

    // 3: half store to the upper half, then half/word/byte loads
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008234, 32'h000000AA, 1'b0, 4, 1);
    wait_done();
    chk("mem4_after_half", mem[4], 32'h8234AAEF);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8234, 1'b0, 3, 0);
    wait_done();
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00008234, 1'b0, 3, 0);
    wait_done();
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8234AAEF, 1'b0, 3, 0);
    wait_done();
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000082, 1'b0, 3, 0);
    wait_done();
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 3, 0);
    wait_done();

    // Last in-range word
    issue(1'b1, 2'b10, 1'b0, 32'h1FC, 32'h12345678, 32'hFFFFFFEF, 1'b0, 2, 1);
    wait_done();
    issue(1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0, 32'h12345678, 1'b0, 3, 0);
    wait_done();

    // 4: rejected requests: misaligned word, misaligned half store, size 11, out of range
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h12345678, 1'b1, 1, 0);
    wait_done();
    issue(1'b1, 2'b01, 1'b0, 32'h01, 32'h0000FFFF, 32'h12345678, 1'b1, 1, 0);
    wait_done();
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b1, 1, 0);
    wait_done();
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h12345678, 1'b1, 1, 0);
    wait_done();
    issue(1'b1, 2'b10, 1'b0, 32'h210, 32'hCAFEF00D, 32'h12345678, 1'b1, 1, 0);
    wait_done();
    chk("mem4_after_errors", mem[4], 32'h8234AAEF);

    // 5: reset during RD2 of a byte store
    issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055, 32'h0, 1'b0, 4, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("midreset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mem4_after_abort", mem[4], 32'h8234AAEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8234AAEF, 1'b0, 3, 0);
    wait_done();

    // 6: cpu_req held high for 10 cycles: accepted in cycles N, N+4, N+8
    @(negedge clk);
    bus.cpu_we = 1'b0; bus.cpu_size = 2'b10; bus.cpu_sign = 1'b0;
    bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'h0;
    bus.cpu_req = 1'b1;
    rc = cyc;
    for (int k = 0; k < 3; k++) begin
      e.rdata = 32'h8234AAEF; e.err = 1'b0; e.lat = 3; e.wea = 0; e.req_cyc = rc + 4 * k;
      exp_q.push_back(e);
    end
    repeat (10) @(negedge clk);
    bus.cpu_req = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
